alu_apb_requester: RTL

- APB requester that drives the ALU's APB completer: control, operand, result and status registers.
- Accepts single register commands from a local initiator (test sequencer or host bridge) over a valid/ready handshake.
- Runs the APB SETUP/ACCESS phases, honours wait states and a transfer timeout.
- Returns read data and error status over a separate valid/ready response channel.

---
 rtl/alu_apb_pkg.sv | 24 ++
 rtl/apb_wait_timer.sv | 42 ++++
 rtl/alu_apb_requester.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_apb_pkg.sv
// Shared definitions for the ALU APB requester and its completer.
// - apb_state_e : requester FSM states
// - REG_*       : completer register map (word index on the APB address bus)
// - OP_CODE_*   : operation codes written into the REG_CTRL operation field
package alu_apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  // Register map, kept identical on the completer side.
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_0      = 1;
  localparam int unsigned REG_1      = 2;
  localparam int unsigned REG_RES    = 3;
  localparam int unsigned REG_STATUS = 4;

  // Operation codes carried in REG_CTRL.
  localparam logic [1:0] OP_CODE_A = 2'b01;
  localparam logic [1:0] OP_CODE_B = 2'b10;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : load the counter with zero (has priority over inc_i)
//   inc_i         : count one more wait state
//   expired_o     : counter sits at TimeoutCycles-1; tied low when TimeoutCycles == 0
module apb_wait_timer #(
  parameter int unsigned TimeoutCycles = 16,
  parameter int unsigned CntW          = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned LastVal = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CntW-1:0] LastCnt = CntW'(LastVal);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TimeoutCycles != 0) && (cnt_q == LastCnt);

endmodule

// File: rtl/alu_apb_requester.sv
// APB requester driving the ALU register completer.
// Accepts one register command at a time on the cmd_* valid/ready channel, runs the
// APB SETUP/ACCESS phases (with wait states and an optional timeout) and returns the
// outcome on the rsp_* valid/ready channel.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata: command channel from the local initiator
//   rsp_valid/ready/rdata/err/timeout: response channel back to the initiator
//   addr, sel, en, write, wdata     : APB request signals to the completer
//   ready, rdata, slv_err           : APB completer replies
module alu_apb_requester
  import alu_apb_pkg::*;
#(
  parameter int unsigned REG_NUMBER     = 5,
  parameter int unsigned APB_BUS_SIZE   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned AddrW          = $clog2(REG_NUMBER)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AddrW-1:0]        cmd_addr,
  input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
  // Response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [APB_BUS_SIZE-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB requester side
  output logic [AddrW-1:0]        addr,
  output logic                    sel,
  output logic                    en,
  output logic                    write,
  output logic [APB_BUS_SIZE-1:0] wdata,
  input  logic                    ready,
  input  logic [APB_BUS_SIZE-1:0] rdata,
  input  logic                    slv_err
);

  apb_state_e state_q, state_d;

  logic                    sel_q, sel_d;
  logic                    en_q, en_d;
  logic                    write_q, write_d;
  logic [AddrW-1:0]        addr_q, addr_d;
  logic [APB_BUS_SIZE-1:0] wdata_q, wdata_d;

  logic                    rsp_valid_q, rsp_valid_d;
  logic [APB_BUS_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept;
  logic timer_clr, timer_inc, timer_expired;

  // A pending response blocks new commands, so at most one transfer is in flight.
  assign cmd_ready  = (state_q == StIdle) && !rsp_valid_q;
  assign cmd_accept = cmd_valid && cmd_ready;

  apb_wait_timer #(
    .TimeoutCycles (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (timer_clr),
    .inc_i     (timer_inc),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    en_d          = en_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;

    // Response handshake; the payload is left in place, only valid drops.
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          addr_d    = cmd_addr;
          write_d   = cmd_write;
          wdata_d   = cmd_wdata;
          sel_d     = 1'b1;
          timer_clr = 1'b1;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        en_d    = 1'b1;
        state_d = StAccess;
      end

      StAccess: begin
        if (ready) begin
          sel_d         = 1'b0;
          en_d          = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = slv_err;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = write_q ? '0 : rdata;
          state_d       = StIdle;
        end else if (timer_expired) begin
          sel_d         = 1'b0;
          en_d          = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = StIdle;
        end else begin
          timer_inc = 1'b1;
        end
      end

      default: begin
        sel_d   = 1'b0;
        en_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sel_q         <= 1'b0;
      en_q          <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      en_q          <= en_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign addr        = addr_q;
  assign sel         = sel_q;
  assign en          = en_q;
  assign write       = write_q;
  assign wdata       = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
